dbus_responder: RTL
===================

DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 Parameter BASE, default 32'h0000_1000: first word address decoded by this responder.
REQ-002 Parameter DEPTH_LOG2, default 10: storage depth is 2**DEPTH_LOG2 32-bit words.
REQ-003 Port clk  input  1  clock; all state changes on the active edge.
REQ-004 Port reset_n  input  1  reset; reset_n is synchronous and active-low.
REQ-005 Port strobe  input  1  bus access request from the core; held high for a contiguous burst of one or more cycles per access.
REQ-006 Port mem_rw  input  1  write qualifier; high in a strobe cycle = write, low = read.
REQ-007 Port d_addr  input  32  word address from the core.
REQ-008 Port d_data  inout  32  write data from the core; read data driven by this block.
REQ-009 Port fault  output  1  sticky out-of-range access flag.
REQ-010 Port rd_count  output  16  number of completed read bursts, saturating.
REQ-011 Port wr_count  output  16  number of committed writes, saturating.

Function
REQ-012 Address decode: offset = d_addr - BASE (32-bit unsigned wrap); in range iff offset < 2**DEPTH_LOG2; index = offset[DEPTH_LOG2-1:0].
REQ-013 State machine states: IDLE, READ, WRITE, DONE, FAULT.
REQ-014 A burst starts in any cycle with strobe high while in IDLE; d_addr is captured on that edge; later d_addr changes within the burst are ignored.
REQ-015 Burst start, in range, mem_rw low: RAM[index] registered into rdata; next state READ.
REQ-016 Burst start, in range, mem_rw high: RAM[index] <= d_data on that edge; wr_count increments; next state DONE.
REQ-017 Burst start, in range, mem_rw low, followed by mem_rw high in a later cycle of the same burst: single write to captured address with d_data of the first mem_rw-high cycle; wr_count increments; next state DONE.
REQ-018 At most one RAM write per burst; further mem_rw-high cycles in DONE are ignored.
REQ-019 Read latency one cycle: d_data carries rdata in every cycle where state is READ and strobe is high and mem_rw is low.
REQ-020 d_data is high-impedance in every other cycle, including all mem_rw-high cycles and all FAULT-state cycles.
REQ-021 rd_count increments on the edge where strobe falls (strobe low) while state is READ.
REQ-022 Burst start with out-of-range address: no RAM access, d_data stays high-impedance, fault set to 1, next state FAULT.
REQ-023 fault is sticky: cleared only by reset; later accesses still serviced normally.
REQ-024 READ, DONE and FAULT return to IDLE on the first edge with strobe low; a new burst needs at least one strobe-low cycle.
REQ-025 WRITE state is transient: held only when a write is pending on the captured address for the current edge; it never lasts more than one cycle.
REQ-026 Counters saturate at 16'hFFFF; no wrap.
REQ-027 Read of a location in the same burst as its write returns the pre-write value (rdata captured at burst start).
REQ-028 Accesses with BASE + 2**DEPTH_LOG2 overflowing 32 bits decode by the wrapped offset rule of REQ-012 only.

Reset
REQ-029 With reset_n low at an edge: state IDLE, fault 0, rd_count 0, wr_count 0, rdata 0, d_data high-impedance from that edge.
REQ-030 Reset does not modify RAM contents; RAM power-up contents are unspecified.
REQ-031 Reset mid-burst aborts the burst: no write, no count; strobe still high after release counts as a new burst start.

Verification
REQ-032 Write then read: strobe 3 cycles, d_addr 32'h1005, mem_rw high in cycle 2, d_data 32'hDEADBEEF; strobe low 1 cycle; read burst 3 cycles at 32'h1005 -> d_data 32'hDEADBEEF in read cycles 2 and 3, high-impedance in cycle 1; wr_count 1, rd_count 1.
REQ-033 Out of range: strobe at d_addr 32'h0FFF and at 32'h1400 -> fault 1 after first edge, d_data high-impedance, counters unchanged, RAM unchanged.
REQ-034 Boundary: write 32'h1 at 32'h1000 and 32'h2 at 32'h13FF, read both -> 32'h1 and 32'h2, fault 0.
REQ-035 Multiple mem_rw cycles: burst with mem_rw high for 3 cycles, d_data 32'hA, 32'hB, 32'hC -> location holds 32'hA, wr_count 1.
REQ-036 Address change mid-burst: read burst starts at 32'h1001 (holds 32'h11), d_addr moves to 32'h1002 in cycle 2 -> d_data 32'h11.
REQ-037 Reset mid-burst and saturation: reset_n low during a write burst's mem_rw cycle -> no write, counters 0; 65 537 read bursts -> rd_count 16'hFFFF.

Source files
------------

// File: rtl/dbus_responder.sv
// dbus_responder: word-addressed data-bus slave with local RAM, sticky range fault and saturating burst counters
module dbus_responder #(
   parameter logic [31:0] BASE       = 32'h0000_1000,
   parameter int          DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        strobe,
   input  logic        mem_rw,
   input  logic [31:0] d_addr,
   inout  wire  [31:0] d_data,
   output logic        fault,
   output logic [15:0] rd_count,
   output logic [15:0] wr_count
);
   typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, FAULT} state_t;
   logic [31:0] mem [1 << DEPTH_LOG2];
   state_t state_q, state_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d, wr_idx;
   logic [31:0] rdata_q, rdata_d, offset;
   logic fault_q, fault_d, in_range, wr_en;
   logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
   assign offset   = d_addr - BASE;
   assign in_range = offset[31:DEPTH_LOG2] == '0;
   assign fault    = fault_q;
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
   assign d_data   = (reset_n && state_q == READ && strobe && !mem_rw) ? rdata_q : 'z;
   // next-state: burst start decode, single late write from READ, return to IDLE on strobe low
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      rdata_d    = rdata_q;
      fault_d    = fault_q;
      rd_count_d = rd_count_q;
      wr_count_d = wr_count_q;
      wr_en      = 1'b0;
      wr_idx     = idx_q;
      case (state_q)
         IDLE: if (strobe) begin
            idx_d  = offset[DEPTH_LOG2-1:0];
            wr_idx = offset[DEPTH_LOG2-1:0];
            if (!in_range) begin
               fault_d = 1'b1;
               state_d = FAULT;
            end else if (mem_rw) begin
               wr_en   = 1'b1;
               state_d = DONE;
            end else begin
               rdata_d = mem[offset[DEPTH_LOG2-1:0]];
               state_d = READ;
            end
         end
         READ: if (!strobe) begin
            rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
            state_d    = IDLE;
         end else if (mem_rw) begin
            wr_en   = 1'b1;
            state_d = DONE;
         end
         WRITE, DONE, FAULT: state_d = strobe ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
      if (state_q == FAULT && strobe) state_d = FAULT;
      if (wr_en) wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
   end
   // control state registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         rdata_q    <= '0;
         fault_q    <= 1'b0;
         rd_count_q <= '0;
         wr_count_q <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         rdata_q    <= rdata_d;
         fault_q    <= fault_d;
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
      end
   end
   // RAM write port; contents survive reset but a reset edge suppresses the write
   always_ff @(posedge clk) begin
      if (reset_n && wr_en) mem[wr_idx] <= d_data;
   end
endmodule
